// File: rtl/cmp_lgez_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential LGEZ comparator.
// The slave side is the comparator; the master side is the operand source
// together with the result consumer.
interface cmp_lgez_seq_ctrl_if #(
  parameter int p_WIDTH = 8,
  parameter int p_SLICE = 2
);
  localparam int c_N     = p_WIDTH / p_SLICE;
  localparam int c_CYC_W = $clog2(c_N) + 1;

  logic               i_valid;
  logic               o_ready;
  logic [p_WIDTH-1:0] i_x;
  logic [p_WIDTH-1:0] i_y;
  logic               o_valid;
  logic               i_ready;
  logic [1:0]         o_code;
  logic [c_CYC_W-1:0] o_cycles;

  modport slave (
    input  i_valid, i_x, i_y, i_ready,
    output o_ready, o_valid, o_code, o_cycles
  );

  modport master (
    output i_valid, i_x, i_y, i_ready,
    input  o_ready, o_valid, o_code, o_cycles
  );
endinterface

// File: rtl/cmp_lgez_seq_ctrl.sv
// Sequential wide comparator: one p_SLICE-bit LGEZ slice is reused over
// several cycles, most significant slice first. The running code in acc
// reproduces what a full-width comparator would report:
//   00 both zero, 11 equal and non-zero, 01 x<y, 10 x>y.
// Once acc is 01/10 the answer is fixed, because lower slices cannot
// override a difference found in a higher slice; p_EARLY exploits that.
module cmp_lgez_seq_ctrl #(
  parameter int p_WIDTH = 8,
  parameter int p_SLICE = 2,
  parameter int p_EARLY = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  cmp_lgez_seq_ctrl_if.slave bus
);

  localparam int c_N     = p_WIDTH / p_SLICE;
  localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_CYC_W = $clog2(c_N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One LGEZ slice compare of two unsigned p_SLICE-bit fields.
  function automatic logic [1:0] slice_code(input logic [p_SLICE-1:0] a,
                                            input logic [p_SLICE-1:0] b);
    logic [1:0] r;
    if (a < b) begin
      r = 2'b01;
    end else if (a > b) begin
      r = 2'b10;
    end else if (a == {p_SLICE{1'b0}}) begin
      r = 2'b00;
    end else begin
      r = 2'b11;
    end
    return r;
  endfunction

  // Fold one slice result into the accumulated code; a decided LESS or
  // GREATER from a more significant slice is sticky.
  function automatic logic [1:0] merge_code(input logic [1:0] acc,
                                            input logic [1:0] s);
    logic [1:0] r;
    if ((acc == 2'b01) || (acc == 2'b10)) begin
      r = acc;
    end else if ((s == 2'b01) || (s == 2'b10)) begin
      r = s;
    end else if ((acc == 2'b11) || (s == 2'b11)) begin
      r = 2'b11;
    end else begin
      r = 2'b00;
    end
    return r;
  endfunction

  state_t             state_q,  state_d;
  logic [p_WIDTH-1:0] x_q,      x_d;
  logic [p_WIDTH-1:0] y_q,      y_d;
  logic [1:0]         acc_q,    acc_d;
  logic [c_IDX_W-1:0] idx_q,    idx_d;
  logic [1:0]         code_q,   code_d;
  logic [c_CYC_W-1:0] cycles_q, cycles_d;
  logic               valid_q,  valid_d;
  logic               ready_q,  ready_d;

  logic [p_WIDTH-1:0] x_shift_s;
  logic [p_WIDTH-1:0] y_shift_s;
  logic [p_SLICE-1:0] x_slice_s;
  logic [p_SLICE-1:0] y_slice_s;
  logic [1:0]         slice_s;
  logic [1:0]         merged_s;
  logic               last_s;
  logic               decided_s;

  // Select the current slice (MSB first) and compute its merged code.
  always_comb begin
    x_shift_s = x_q << (idx_q * p_SLICE);
    y_shift_s = y_q << (idx_q * p_SLICE);
    x_slice_s = x_shift_s[p_WIDTH-1 -: p_SLICE];
    y_slice_s = y_shift_s[p_WIDTH-1 -: p_SLICE];
    slice_s   = slice_code(x_slice_s, y_slice_s);
    merged_s  = merge_code(acc_q, slice_s);
    last_s    = (idx_q == c_IDX_W'(c_N - 1));
    decided_s = (merged_s == 2'b01) || (merged_s == 2'b10);
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    code_d   = code_q;
    cycles_d = cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid && ready_q) begin
          x_d     = bus.i_x;
          y_d     = bus.i_y;
          acc_d   = 2'b00;
          idx_d   = {c_IDX_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_d = merged_s;
        if (last_s || ((p_EARLY != 0) && decided_s)) begin
          state_d  = ST_DONE;
          code_d   = merged_s;
          cycles_d = c_CYC_W'(idx_q) + c_CYC_W'(1);
        end else begin
          state_d = ST_RUN;
          idx_d   = idx_q + c_IDX_W'(1);
        end
      end

      ST_DONE: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags follow the state being entered so they are registered.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      x_q      <= {p_WIDTH{1'b0}};
      y_q      <= {p_WIDTH{1'b0}};
      acc_q    <= 2'b00;
      idx_q    <= {c_IDX_W{1'b0}};
      code_q   <= 2'b00;
      cycles_q <= {c_CYC_W{1'b0}};
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      cycles_q <= cycles_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_code   = code_q;
  assign bus.o_cycles = cycles_q;

endmodule

// File: tb/tb_cmp_lgez_seq_ctrl.sv
// Scoreboard bench for cmp_lgez_seq_ctrl. Three instances:
//   a: 8/2 early-exit, b: 8/2 full-run, c: 4/2 early-exit exhaustive sweep.
module tb_cmp_lgez_seq_ctrl;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] cyc;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  bit   stall_c;
  int   checks;
  int   errors;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  cmp_lgez_seq_ctrl_if #(.p_WIDTH(8), .p_SLICE(2)) if_a ();
  cmp_lgez_seq_ctrl_if #(.p_WIDTH(8), .p_SLICE(2)) if_b ();
  cmp_lgez_seq_ctrl_if #(.p_WIDTH(4), .p_SLICE(2)) if_c ();

  cmp_lgez_seq_ctrl #(.p_WIDTH(8), .p_SLICE(2), .p_EARLY(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .bus(if_a)
  );
  cmp_lgez_seq_ctrl #(.p_WIDTH(8), .p_SLICE(2), .p_EARLY(0)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .bus(if_b)
  );
  cmp_lgez_seq_ctrl #(.p_WIDTH(4), .p_SLICE(2), .p_EARLY(1)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .bus(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected entry per accepted result.
  always @(negedge clk) begin
    if (!rst_a && if_a.o_valid && if_a.i_ready) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got code %b with nothing expected", if_a.o_code);
      end else begin
        e_a = q_a.pop_front();
        chk("a_code", 32'(if_a.o_code), 32'(e_a.code));
        chk("a_cycles", 32'(if_a.o_cycles), 32'(e_a.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && if_b.o_valid && if_b.i_ready) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got code %b with nothing expected", if_b.o_code);
      end else begin
        e_b = q_b.pop_front();
        chk("b_code", 32'(if_b.o_code), 32'(e_b.code));
        chk("b_cycles", 32'(if_b.o_cycles), 32'(e_b.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_c && if_c.o_valid && if_c.i_ready) begin
      if (q_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected: got code %b with nothing expected", if_c.o_code);
      end else begin
        e_c = q_c.pop_front();
        chk("c_code", 32'(if_c.o_code), 32'(e_c.code));
        chk("c_cycles", 32'(if_c.o_cycles), 32'(e_c.cyc));
      end
    end
  end

  // Random consumer stalls for instance c.
  initial begin
    if_c.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_c) if_c.i_ready = 1'($urandom_range(0, 1));
      else         if_c.i_ready = 1'b1;
    end
  end

  task automatic issue_a(input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] code, input logic [3:0] cyc);
    int n = 0;
    @(negedge clk);
    while (!if_a.o_ready && n < 100) begin @(negedge clk); n++; end
    chk("a_ready_wait", 32'(if_a.o_ready), 32'd1);
    if (if_a.o_ready) begin
      if_a.i_x = x; if_a.i_y = y; if_a.i_valid = 1'b1;
      q_a.push_back('{code, cyc});
      @(posedge clk); #1;
      if_a.i_valid = 1'b0;
    end
  endtask

  task automatic issue_b(input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] code, input logic [3:0] cyc, input bit push);
    int n = 0;
    @(negedge clk);
    while (!if_b.o_ready && n < 100) begin @(negedge clk); n++; end
    chk("b_ready_wait", 32'(if_b.o_ready), 32'd1);
    if (if_b.o_ready) begin
      if_b.i_x = x; if_b.i_y = y; if_b.i_valid = 1'b1;
      if (push) q_b.push_back('{code, cyc});
      @(posedge clk); #1;
      if_b.i_valid = 1'b0;
    end
  endtask

  task automatic issue_c(input logic [3:0] x, input logic [3:0] y,
                         input logic [1:0] code, input logic [3:0] cyc);
    int n = 0;
    @(negedge clk);
    while (!if_c.o_ready && n < 100) begin @(negedge clk); n++; end
    if (!if_c.o_ready) begin
      chk("c_ready_wait", 32'(if_c.o_ready), 32'd1);
    end else begin
      if_c.i_x = x; if_c.i_y = y; if_c.i_valid = 1'b1;
      q_c.push_back('{code, cyc});
      @(posedge clk); #1;
      if_c.i_valid = 1'b0;
    end
  endtask

  function automatic int qsize(input int which);
    int r;
    case (which)
      0:       r = q_a.size();
      1:       r = q_b.size();
      default: r = q_c.size();
    endcase
    return r;
  endfunction

  task automatic drain(input int which, input string name);
    int n = 0;
    while (qsize(which) != 0 && n < 2000) begin @(negedge clk); n++; end
    chk(name, 32'(qsize(which)), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Directed vectors for instance a: x, y, code, slices used (hand computed).
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] code;
    logic [3:0] cyc;
  } vec_t;

  vec_t vecs[5];
  int   lat;
  int   seen;
  logic [1:0] rc;
  logic [3:0] rcyc;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; stall_c = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.i_valid = 1'b0; if_a.i_x = 8'h00; if_a.i_y = 8'h00; if_a.i_ready = 1'b1;
    if_b.i_valid = 1'b0; if_b.i_x = 8'h00; if_b.i_y = 8'h00; if_b.i_ready = 1'b1;
    if_c.i_valid = 1'b0; if_c.i_x = 4'h0; if_c.i_y = 4'h0;

    vecs[0] = '{8'hA5, 8'hA5, 2'b11, 4'd4};
    vecs[1] = '{8'h40, 8'h80, 2'b01, 4'd1};
    vecs[2] = '{8'hFF, 8'h00, 2'b10, 4'd1};
    vecs[3] = '{8'h12, 8'h13, 2'b01, 4'd4};
    vecs[4] = '{8'h0C, 8'h08, 2'b10, 4'd3};

    repeat (3) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("a_rst_valid",  32'(if_a.o_valid),  32'd0);
    chk("a_rst_ready",  32'(if_a.o_ready),  32'd1);
    chk("a_rst_code",   32'(if_a.o_code),   32'd0);
    chk("a_rst_cycles", 32'(if_a.o_cycles), 32'd0);
    chk("b_rst_ready",  32'(if_b.o_ready),  32'd1);
    chk("c_rst_ready",  32'(if_c.o_ready),  32'd1);

    // Zero operands and latency from accept to o_valid.
    issue_a(8'h00, 8'h00, 2'b00, 4'd4);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (if_a.o_valid) break;
    end
    chk("a_latency", 32'(lat), 32'd4);
    drain(0, "a_drain_zero");

    for (int i = 0; i < 5; i++) begin
      issue_a(vecs[i].x, vecs[i].y, vecs[i].code, vecs[i].cyc);
      drain(0, "a_drain_vec");
    end

    // Result held under consumer stall; new operands are ignored.
    if_a.i_ready = 1'b0;
    issue_a(8'h03, 8'h02, 2'b10, 4'd4);
    lat = 0;
    while (!if_a.o_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("a_stall_valid_seen", 32'(if_a.o_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if_a.i_x = 8'($urandom); if_a.i_y = 8'($urandom);
      if_a.i_valid = ~if_a.i_valid;
      @(negedge clk);
      chk("a_stall_valid",  32'(if_a.o_valid),  32'd1);
      chk("a_stall_code",   32'(if_a.o_code),   32'd2);
      chk("a_stall_cycles", 32'(if_a.o_cycles), 32'd4);
      chk("a_stall_ready",  32'(if_a.o_ready),  32'd0);
    end
    @(posedge clk); #1;
    if_a.i_valid = 1'b0; if_a.i_ready = 1'b1;
    drain(0, "a_drain_stall");
    seen = 0;
    repeat (8) begin @(negedge clk); if (if_a.o_valid) seen++; end
    chk("a_no_second_accept", 32'(seen), 32'd0);

    // Full-run variant.
    issue_b(8'h40, 8'h80, 2'b01, 4'd4, 1'b1);
    drain(1, "b_drain_full");

    // Reset during RUN at idx=1 drops the op.
    issue_b(8'hF0, 8'h0F, 2'b10, 4'd4, 1'b0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_after_rst_valid", 32'(if_b.o_valid), 32'd0);
    chk("b_after_rst_ready", 32'(if_b.o_ready), 32'd1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (if_b.o_valid) seen++; end
    chk("b_dropped_no_valid", 32'(seen), 32'd0);
    issue_b(8'h01, 8'h01, 2'b11, 4'd4, 1'b1);
    drain(1, "b_drain_after_rst");

    // Exhaustive 4-bit sweep against a full-width reference with stalls.
    stall_c = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        if (x < y)       rc = 2'b01;
        else if (x > y)  rc = 2'b10;
        else if (x == 0) rc = 2'b00;
        else             rc = 2'b11;
        rcyc = ((x / 4) != (y / 4)) ? 4'd1 : 4'd2;
        issue_c(4'(x), 4'(y), rc, rcyc);
      end
    end
    drain(2, "c_drain_sweep");
    stall_c = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
